bus_arbiter_nm: RTL and testbench
=================================

// Module: bus_arbiter_nm
// PURPOSE
//  N-master system-bus arbiter with split-transaction support; next generation of the 2-master arbiter.
//  Grants one master at a time and drives the master-select mux. Tracks one outstanding split
//  owned by the split-capable slave and lets other masters use non-split slaves meanwhile.
//  Adds selectable fixed/round-robin priority and a bounded bus-hold timeout.
// PARAMETERS
//  N_MASTERS  4   number of masters, 2..8
//  RR_MODE    1   0 = fixed priority (index 0 highest), 1 = round-robin
//  MAX_HOLD   16  max consecutive GRANT cycles while others request; 0 = unlimited
//  MW         $clog2(N_MASTERS)  derived, msel width
// PORTS
//  clk          in   1    bus clock
//  rstn         in   1    reset, asynchronous, active-low
//  breq         in   N    per-master bus request, held for whole transaction
//  sready_nsp   in   1    AND of all non-split slave ready signals
//  sreadysp     in   1    split-capable slave ready
//  ssplit       in   1    split-capable slave: split active (1) / released (0)
//  bgrant       out  N    one-hot grant, registered
//  msel         out  MW   index of granted master; 0 when idle
//  msplit       out  N    per-master "your transaction is split", registered
//  split_grant  out  1    1-cycle pulse: split owner resumed, slave may continue
// BEHAVIOUR
//  Reset (async, rstn=0): state=IDLE, bgrant=0, msel=0, msplit=0, split_grant=0, split_vld=0,
//   split_own=0, rr_ptr=0, hold_cnt=0. Release takes effect on next clk edge.
//  States: IDLE, GRANT. Grant owner g registered; bgrant=onehot(g) in GRANT only, else 0.
//  IDLE, ssplit=0: if split_vld -> GRANT(split_own) (resume has priority over all requests);
//   else if sready_nsp&sreadysp and |breq -> GRANT(winner) ; else stay IDLE.
//  IDLE, ssplit=1: candidates = breq & ~onehot(split_own) if split_vld, else none;
//   needs sready_nsp only; winner -> GRANT, else stay IDLE.
//  Winner: RR_MODE=0 lowest set index; RR_MODE=1 first set index at/after rr_ptr, wrapping
//   N-1 -> 0. On any GRANT entry rr_ptr <= (winner+1) mod N (resume entry does not move rr_ptr).
//  GRANT(g) exits to IDLE next cycle when any of: breq[g]=0; split_vld=0 & ssplit=1 (new split:
//   split_vld<=1, split_own<=g, msplit[g]<=1); MAX_HOLD!=0 & hold_cnt==MAX_HOLD-1 & (breq&~onehot(g))!=0.
//  GRANT(g), split_vld & split_own==g & ssplit=0: split_vld<=0, msplit[g]<=0, split_grant<=1 one cycle.
//  ssplit=1 while split_vld=1: no new split recorded (single split slave), grant unaffected.
//  hold_cnt: clears on GRANT entry, +1 per GRANT cycle, saturates at MAX_HOLD-1; width $clog2(MAX_HOLD+1).
//  Grant latency: request seen in IDLE -> bgrant high next cycle; minimum 1 IDLE cycle between grants.
//  msplit[g] stays high while split pending even if master drops breq.
//  split_grant defaults 0 every cycle not setting it.
// STRUCTURE
//  Package bus_arb_pkg: state enum {IDLE, GRANT}, onehot/encode functions, MAX_MASTERS=8.
//  Sub-module arb_rr_pick (N, RR_MODE): comb. masked priority pick (req, ptr) -> idx, valid.
//  Top: one FSM always block (async reset) + two instances not required; one picker suffices.
// TESTING
//  T1 reset: rstn=0 mid-GRANT(2) -> bgrant=0, msel=0, msplit=0 immediately, no clk needed.
//  T2 RR: N=4, breq=4'b1111 held, all ready -> grant order 0,1,2,3,0 with IDLE gap each.
//  T3 fixed: RR_MODE=0, breq=4'b1010 -> master 1 granted repeatedly; master 3 only when breq[1]=0.
//  T4 split: GRANT(1), ssplit=1 -> msplit=4'b0010, IDLE; breq[2]=1 -> GRANT(2); ssplit=0 in IDLE
//   -> GRANT(1) next, split_grant=1 exactly one cycle in GRANT, msplit=0.
//  T5 timeout: MAX_HOLD=4, breq=4'b0011 held -> bgrant[0] high exactly 4 cycles, then master 1.
//  T6 second split: split_own=0 pending, GRANT(3) sees ssplit=1 -> msplit[3] stays 0, state holds.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the N-master split-capable bus arbiter.
// Upper bound on master count, state encoding and index/one-hot conversions.
package bus_arb_pkg;

   localparam int MAX_MASTERS = 8;
   localparam int MAX_IDX_W   = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   function automatic logic [MAX_MASTERS-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
      logic [MAX_MASTERS-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   function automatic logic [MAX_IDX_W-1:0] encode(input logic [MAX_MASTERS-1:0] vec);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int i = MAX_MASTERS - 1; i >= 0; i--) begin
         if (vec[i]) idx = MAX_IDX_W'(i);
      end
      return idx;
   endfunction

   // (a + b) mod n for a, b already below n
   function automatic int wrap_add(input int a, input int b, input int n);
      int s;
      s = a + b;
      return (s >= n) ? s - n : s;
   endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational priority picker: first request at/after i_ptr (round-robin) or the
// lowest requesting index (fixed priority, pointer ignored).
module arb_rr_pick
   import bus_arb_pkg::*;
#(
   parameter  int N       = 4,
   parameter  int RR_MODE = 1,
   localparam int MW      = $clog2(N)
)(
   input  logic [N-1:0]  i_req,
   input  logic [MW-1:0] i_ptr,
   output logic [MW-1:0] o_idx,
   output logic          o_valid
);

   logic [MW-1:0]  w_ptr;
   logic [2*N-1:0] w_req2;
   logic [N-1:0]   w_rot;

   assign w_ptr  = (RR_MODE != 0) ? i_ptr : '0;
   assign w_req2 = {i_req, i_req};
   // Rotate so that the pointer position lands at bit 0; doubling handles the wrap.
   assign w_rot  = N'(w_req2 >> w_ptr);

   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            o_valid = 1'b1;
            o_idx   = MW'(wrap_add(int'(w_ptr), k, N));
         end
      end
   end

endmodule

// File: rtl/bus_arbiter_nm.sv
// N-master bus arbiter: one grant at a time, one outstanding split owned by the
// split-capable slave, fixed or round-robin priority and a bounded hold timeout.
module bus_arbiter_nm
   import bus_arb_pkg::*;
#(
   parameter  int N_MASTERS = 4,
   parameter  int RR_MODE   = 1,
   parameter  int MAX_HOLD  = 16,
   localparam int MW        = $clog2(N_MASTERS)
)(
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [N_MASTERS-1:0] breq,
   input  logic                 sready_nsp,
   input  logic                 sreadysp,
   input  logic                 ssplit,
   output logic [N_MASTERS-1:0] bgrant,
   output logic [MW-1:0]        msel,
   output logic [N_MASTERS-1:0] msplit,
   output logic                 split_grant
);

   localparam int            HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

   arb_state_e             r_state,       w_state_next;
   logic [MW-1:0]          r_owner,       w_owner_next;
   logic                   r_split_vld,   w_split_vld_next;
   logic [MW-1:0]          r_split_own,   w_split_own_next;
   logic [MW-1:0]          r_rr_ptr,      w_rr_ptr_next;
   logic [HW-1:0]          r_hold_cnt,    w_hold_next;
   logic [N_MASTERS-1:0]   r_msplit,      w_msplit_next;
   logic                   r_split_grant, w_split_grant_next;

   logic [N_MASTERS-1:0]   w_owner_oh;
   logic [N_MASTERS-1:0]   w_split_oh;
   logic [N_MASTERS-1:0]   w_cand;
   logic [MW-1:0]          w_win_idx;
   logic                   w_win_vld;

   assign w_owner_oh = N_MASTERS'(onehot(MAX_IDX_W'(r_owner)));
   assign w_split_oh = N_MASTERS'(onehot(MAX_IDX_W'(r_split_own)));

   // While a split is pending only non-split slaves are usable, so its owner sits out.
   always_comb begin
      w_cand = '0;
      if (r_state == IDLE) begin
         if (!ssplit) begin
            if (sready_nsp && sreadysp) w_cand = breq;
         end else if (r_split_vld && sready_nsp) begin
            w_cand = breq & ~w_split_oh;
         end
      end
   end

   arb_rr_pick #(
      .N       (N_MASTERS),
      .RR_MODE (RR_MODE)
   ) u_pick (
      .i_req   (w_cand),
      .i_ptr   (r_rr_ptr),
      .o_idx   (w_win_idx),
      .o_valid (w_win_vld)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state       <= IDLE;
         r_owner       <= '0;
         r_split_vld   <= 1'b0;
         r_split_own   <= '0;
         r_rr_ptr      <= '0;
         r_hold_cnt    <= '0;
         r_msplit      <= '0;
         r_split_grant <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_owner       <= w_owner_next;
         r_split_vld   <= w_split_vld_next;
         r_split_own   <= w_split_own_next;
         r_rr_ptr      <= w_rr_ptr_next;
         r_hold_cnt    <= w_hold_next;
         r_msplit      <= w_msplit_next;
         r_split_grant <= w_split_grant_next;
      end
   end

   always_comb begin
      w_state_next       = r_state;
      w_owner_next       = r_owner;
      w_split_vld_next   = r_split_vld;
      w_split_own_next   = r_split_own;
      w_rr_ptr_next      = r_rr_ptr;
      w_hold_next        = r_hold_cnt;
      w_msplit_next      = r_msplit;
      w_split_grant_next = 1'b0;
      unique case (r_state)
         IDLE: begin
            // A released split resumes ahead of every request and leaves the pointer alone.
            if (!ssplit && r_split_vld) begin
               w_state_next = GRANT;
               w_owner_next = r_split_own;
               w_hold_next  = '0;
            end else if (w_win_vld) begin
               w_state_next  = GRANT;
               w_owner_next  = w_win_idx;
               w_hold_next   = '0;
               w_rr_ptr_next = MW'(wrap_add(int'(w_win_idx), 1, N_MASTERS));
            end
         end
         GRANT: begin
            if (r_hold_cnt != HOLD_LAST) w_hold_next = r_hold_cnt + HW'(1);
            if (!breq[r_owner]) w_state_next = IDLE;
            if (!r_split_vld && ssplit) begin
               w_state_next            = IDLE;
               w_split_vld_next        = 1'b1;
               w_split_own_next        = r_owner;
               w_msplit_next[r_owner]  = 1'b1;
            end
            if ((MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST) && ((breq & ~w_owner_oh) != '0))
               w_state_next = IDLE;
            if (r_split_vld && (r_split_own == r_owner) && !ssplit) begin
               w_split_vld_next        = 1'b0;
               w_msplit_next[r_owner]  = 1'b0;
               w_split_grant_next      = 1'b1;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      bgrant = '0;
      msel   = '0;
      if (r_state == GRANT) begin
         bgrant = w_owner_oh;
         msel   = r_owner;
      end
   end

   assign msplit      = r_msplit;
   assign split_grant = r_split_grant;

endmodule

// File: tb/tb_bus_arbiter_nm.sv
// Scoreboard bench: instance 0 is round-robin with MAX_HOLD=4, instance 1 fixed priority
// with unlimited hold; each completed grant is compared against a queued expected record.
module tb_bus_arbiter_nm;

   typedef struct {
      int         inst;
      int         master;
      int         len;
      logic [3:0] ms0;
      logic [3:0] ms1;
      int         sg;
   } txn_t;

   logic       clk;
   logic       rstn;
   logic [3:0] breq [2];
   logic       sready_nsp;
   logic       sreadysp;
   logic       ssplit;
   logic [3:0] bgrant [2];
   logic [1:0] msel [2];
   logic [3:0] msplit [2];
   logic       split_grant [2];

   txn_t exp_q[$];
   int   checks;
   int   failures;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic exp_txn(input int inst, input int master, input int len,
                          input logic [3:0] ms0, input logic [3:0] ms1, input int sg);
      txn_t t;
      t.inst   = inst;
      t.master = master;
      t.len    = len;
      t.ms0    = ms0;
      t.ms1    = ms1;
      t.sg     = sg;
      exp_q.push_back(t);
   endtask

   task automatic close_txn(input int inst, input logic [3:0] g, input int len, input logic [1:0] sel,
                            input logic [3:0] ms0, input logic [3:0] ms1, input int sg);
      txn_t       e;
      logic [3:0] eg;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_grant: inst=%0d bgrant=%b len=%0d, required no grant", inst, g, len);
         return;
      end
      e  = exp_q.pop_front();
      eg = 4'b0001 << e.master;
      if (inst != e.inst || g != eg || sel != 2'(e.master) || len != e.len ||
          ms0 != e.ms0 || ms1 != e.ms1 || sg != e.sg) begin
         failures++;
         $display("FAIL grant_txn: got inst=%0d bgrant=%b msel=%0d len=%0d msplit=%b->%b split_grant=%0d, required inst=%0d bgrant=%b msel=%0d len=%0d msplit=%b->%b split_grant=%0d",
                  inst, g, sel, len, ms0, ms1, sg, e.inst, eg, e.master, e.len, e.ms0, e.ms1, e.sg);
      end else begin
         $display("txn inst=%0d master=%0d len=%0d msplit=%b->%b split_grant=%0d ok",
                  inst, e.master, len, ms0, ms1, sg);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      bus_arbiter_nm #(
         .N_MASTERS (4),
         .RR_MODE   ((gi == 0) ? 1 : 0),
         .MAX_HOLD  ((gi == 0) ? 4 : 0)
      ) u_dut (
         .clk         (clk),
         .rstn        (rstn),
         .breq        (breq[gi]),
         .sready_nsp  (sready_nsp),
         .sreadysp    (sreadysp),
         .ssplit      (ssplit),
         .bgrant      (bgrant[gi]),
         .msel        (msel[gi]),
         .msplit      (msplit[gi]),
         .split_grant (split_grant[gi])
      );

      initial begin : mon
         logic [3:0] cur_g;
         logic [3:0] ms0;
         logic [3:0] ms1;
         logic [1:0] sel0;
         int         cur_len;
         int         sg;
         cur_g   = '0;
         ms0     = '0;
         ms1     = '0;
         sel0    = '0;
         cur_len = 0;
         sg      = 0;
         forever begin
            @(negedge clk);
            if (!rstn) begin
               cur_g = '0;
            end else begin
               if (cur_g != '0 && bgrant[gi] != cur_g) begin
                  close_txn(gi, cur_g, cur_len, sel0, ms0, ms1, sg);
                  cur_g = '0;
               end
               if (cur_g == '0 && bgrant[gi] != '0) begin
                  cur_g   = bgrant[gi];
                  cur_len = 0;
                  ms0     = msplit[gi];
                  sel0    = msel[gi];
                  sg      = 0;
               end
               if (cur_g != '0) begin
                  cur_len++;
                  ms1 = msplit[gi];
                  if (split_grant[gi]) sg++;
               end else begin
                  check_val($sformatf("idle_msel[%0d]", gi), int'(msel[gi]), 0);
                  check_val($sformatf("idle_split_grant[%0d]", gi), int'(split_grant[gi]), 0);
               end
            end
         end
      end
   end

   initial begin
      checks     = 0;
      failures   = 0;
      rstn       = 1'b1;
      breq[0]    = '0;
      breq[1]    = '0;
      sready_nsp = 1'b1;
      sreadysp   = 1'b1;
      ssplit     = 1'b0;
      #1 rstn = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         check_val($sformatf("reset_bgrant[%0d]", i), int'(bgrant[i]), 0);
         check_val($sformatf("reset_msel[%0d]", i), int'(msel[i]), 0);
         check_val($sformatf("reset_msplit[%0d]", i), int'(msplit[i]), 0);
         check_val($sformatf("reset_split_grant[%0d]", i), int'(split_grant[i]), 0);
      end
      tick(2);
      rstn = 1'b1;
      tick(1);

      // Round-robin with everyone requesting: each grant ends on the 4-cycle hold limit.
      exp_txn(0, 0, 4, 4'b0000, 4'b0000, 0);
      exp_txn(0, 1, 4, 4'b0000, 4'b0000, 0);
      exp_txn(0, 2, 4, 4'b0000, 4'b0000, 0);
      exp_txn(0, 3, 4, 4'b0000, 4'b0000, 0);
      exp_txn(0, 0, 2, 4'b0000, 4'b0000, 0);
      breq[0] = 4'b1111;
      tick(22);
      breq[0] = 4'b0000;
      tick(3);

      // Split on master 1, master 2 uses the bus meanwhile, then master 1 resumes.
      exp_txn(0, 1, 1, 4'b0000, 4'b0000, 0);
      exp_txn(0, 2, 3, 4'b0010, 4'b0010, 0);
      exp_txn(0, 1, 3, 4'b0010, 4'b0000, 1);
      breq[0] = 4'b0010;
      tick(1);
      ssplit  = 1'b1;
      tick(1);
      breq[0] = 4'b0110;
      tick(3);
      breq[0] = 4'b0010;
      tick(1);
      ssplit  = 1'b0;
      tick(3);
      breq[0] = 4'b0000;
      tick(3);

      // Second split request while master 0's split is pending is ignored.
      exp_txn(0, 0, 1, 4'b0000, 4'b0000, 0);
      exp_txn(0, 3, 3, 4'b0001, 4'b0001, 0);
      exp_txn(0, 0, 2, 4'b0001, 4'b0000, 1);
      breq[0] = 4'b0001;
      tick(1);
      ssplit  = 1'b1;
      tick(1);
      breq[0] = 4'b1001;
      tick(3);
      breq[0] = 4'b0001;
      tick(1);
      ssplit  = 1'b0;
      tick(2);
      breq[0] = 4'b0000;
      tick(3);

      // Hold timeout between two masters.
      exp_txn(0, 0, 4, 4'b0000, 4'b0000, 0);
      exp_txn(0, 1, 4, 4'b0000, 4'b0000, 0);
      exp_txn(0, 0, 1, 4'b0000, 4'b0000, 0);
      breq[0] = 4'b0011;
      tick(11);
      breq[0] = 4'b0000;
      tick(3);

      // Fixed priority: master 1 wins twice, master 3 only once master 1 is quiet.
      exp_txn(1, 1, 3, 4'b0000, 4'b0000, 0);
      exp_txn(1, 1, 3, 4'b0000, 4'b0000, 0);
      exp_txn(1, 3, 2, 4'b0000, 4'b0000, 0);
      breq[1] = 4'b1010;
      tick(3);
      breq[1] = 4'b1000;
      tick(1);
      breq[1] = 4'b1010;
      tick(3);
      breq[1] = 4'b1000;
      tick(3);
      breq[1] = 4'b0000;
      tick(3);

      // No grant until both slave-ready inputs are high.
      exp_txn(1, 0, 2, 4'b0000, 4'b0000, 0);
      sready_nsp = 1'b0;
      sreadysp   = 1'b0;
      breq[1]    = 4'b0001;
      tick(2);
      sready_nsp = 1'b1;
      tick(1);
      sreadysp   = 1'b1;
      tick(2);
      breq[1]    = 4'b0000;
      tick(3);

      // Asynchronous reset in the middle of a grant with a split pending.
      exp_txn(0, 2, 1, 4'b0000, 4'b0000, 0);
      breq[0] = 4'b0100;
      tick(1);
      ssplit  = 1'b1;
      tick(1);
      breq[0] = 4'b1100;
      tick(1);
      check_val("pre_reset_bgrant", int'(bgrant[0]), 4'b1000);
      check_val("pre_reset_msplit", int'(msplit[0]), 4'b0100);
      #2 rstn = 1'b0;
      #1;
      check_val("async_reset_bgrant", int'(bgrant[0]), 0);
      check_val("async_reset_msel", int'(msel[0]), 0);
      check_val("async_reset_msplit", int'(msplit[0]), 0);
      check_val("async_reset_split_grant", int'(split_grant[0]), 0);
      breq[0] = 4'b0000;
      ssplit  = 1'b0;
      tick(2);
      rstn = 1'b1;
      exp_txn(0, 0, 2, 4'b0000, 4'b0000, 0);
      breq[0] = 4'b0001;
      tick(2);
      breq[0] = 4'b0000;
      tick(3);

      for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
      while (exp_q.size() != 0) begin
         txn_t t;
         t = exp_q.pop_front();
         checks++;
         failures++;
         $display("FAIL missing_grant: got none, required inst=%0d master=%0d len=%0d", t.inst, t.master, t.len);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
